// File: rtl/ud_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ud_dec_pkg
//  Description : Shared types and constants for the up/down count decoder.
//                - state_t : decoder FSM states
//                - step_t  : classification of one sample-to-sample step
//                - c_DELTA_* : step deltas, cast to the bus width at the point
//                  of use (c_DELTA_DN = -1 becomes all-ones).
//  Revision    : 1.0  initial release
// ============================================================================
package ud_dec_pkg;

  // Decoder FSM states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    ACQ      = 3'd0,
    SEEN     = 3'd1,
    TRACK_UP = 3'd2,
    TRACK_DN = 3'd3,
    FAULT    = 3'd4
  } state_t;

  // Step classes
  typedef enum logic [1:0] {
    UP    = 2'd0,
    DN    = 2'd1,
    STALL = 2'd2,
    JUMP  = 2'd3
  } step_t;

  // Step deltas, (count - prev) modulo 2**WIDTH
  localparam int c_DELTA_STALL = 0;
  localparam int c_DELTA_UP    = 1;
  localparam int c_DELTA_DN    = -1;

endpackage : ud_dec_pkg
`default_nettype wire

// File: rtl/ud_step_classify.sv
`default_nettype none
// ============================================================================
//  Module      : ud_step_classify
//  Description : Combinational step classifier. Compares a new count sample
//                against the previous one and reports the step class and
//                whether a legal step crossed the wrap boundary.
//  Ports       : i_prev    [WIDTH] previous accepted sample
//                i_count   [WIDTH] current sample
//                o_step    step_t  UP / DN / STALL / JUMP
//                o_wrap_up 1       UP step from MAX to 0
//                o_wrap_dn 1       DN step from 0 to MAX
//  Revision    : 1.0  initial release
// ============================================================================
module ud_step_classify
  import ud_dec_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_count,
  output step_t            o_step,
  output logic             o_wrap_up,
  output logic             o_wrap_dn
);

  localparam logic [WIDTH-1:0] c_D_STALL = WIDTH'(c_DELTA_STALL);
  localparam logic [WIDTH-1:0] c_D_UP    = WIDTH'(c_DELTA_UP);
  localparam logic [WIDTH-1:0] c_D_DN    = WIDTH'(c_DELTA_DN);
  localparam logic [WIDTH-1:0] c_MAX     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ZERO    = {WIDTH{1'b0}};

  // Modular subtraction: the natural WIDTH-bit wrap gives the delta mod 2**WIDTH
  logic [WIDTH-1:0] w_delta;
  assign w_delta = i_count - i_prev;

  always_comb begin
    o_step = JUMP;
    if (w_delta == c_D_STALL) begin
      o_step = STALL;
    end else if (w_delta == c_D_UP) begin
      o_step = UP;
    end else if (w_delta == c_D_DN) begin
      o_step = DN;
    end
  end

  assign o_wrap_up = (o_step == UP) && (i_prev == c_MAX);
  assign o_wrap_dn = (o_step == DN) && (i_prev == c_ZERO);

endmodule : ud_step_classify
`default_nettype wire

// File: rtl/ud_count_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ud_count_decoder
//  Description : Receive-side companion to the up/down counter. Samples the
//                count bus on count_vld, recovers the count direction and
//                flags wraps, stalls and illegal jumps. All outputs are
//                registered; a response appears the cycle after the sample.
//  Config      : REV_CNT_EN - when defined, adds the REV_W parameter, the
//                rev_cnt port and the saturating reversal counter. The
//                counter is cleared by reset only and survives FAULT.
//  Ports       : clk        in   rising-edge clock
//                reset      in   asynchronous active-low reset
//                count      in   [WIDTH] observed counter value
//                count_vld  in   count is a new sample this cycle
//                clr_fault  in   leave FAULT, restart acquisition
//                dir        out  recovered direction, 1=up 0=down
//                dir_vld    out  high while tracking
//                wrap_up    out  pulse: legal up step MAX->0
//                wrap_dn    out  pulse: legal down step 0->MAX
//                stall      out  pulse: sample equal to previous
//                err        out  pulse: illegal jump while tracking
//                fault      out  high while in FAULT
//                run_len    out  [RUN_W] saturating same-direction run length
//                rev_cnt    out  [REV_W] saturating reversal count (REV_CNT_EN)
//  Revision    : 1.0  initial release
// ============================================================================
module ud_count_decoder
  import ud_dec_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RUN_W = 8
`ifdef REV_CNT_EN
  ,
  parameter int REV_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             count_vld,
  input  logic             clr_fault,
  output logic             dir,
  output logic             dir_vld,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             stall,
  output logic             err,
  output logic             fault,
  output logic [RUN_W-1:0] run_len
`ifdef REV_CNT_EN
  ,
  output logic [REV_W-1:0] rev_cnt
`endif
);

  localparam logic [RUN_W-1:0] c_RUN_MAX = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] c_RUN_ONE = RUN_W'(1);
`ifdef REV_CNT_EN
  localparam logic [REV_W-1:0] c_REV_MAX = {REV_W{1'b1}};
  localparam logic [REV_W-1:0] c_REV_ONE = REV_W'(1);
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;

  step_t            w_step;
  logic             w_wrap_up;
  logic             w_wrap_dn;

  ud_step_classify #(
    .WIDTH (WIDTH)
  ) u_classify (
    .i_prev    (r_prev),
    .i_count   (count),
    .o_step    (w_step),
    .o_wrap_up (w_wrap_up),
    .o_wrap_dn (w_wrap_dn)
  );

  // Level outputs decode directly from the state register, so they are
  // registered and clear asynchronously together with the state.
  assign dir_vld = (r_state == TRACK_UP) || (r_state == TRACK_DN);
  assign fault   = (r_state == FAULT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ACQ;
      r_prev  <= '0;
      dir     <= 1'b0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      stall   <= 1'b0;
      err     <= 1'b0;
      run_len <= '0;
`ifdef REV_CNT_EN
      rev_cnt <= '0;
`endif
    end else begin
      // Pulses default low; only a classified valid sample raises one
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      stall   <= 1'b0;
      err     <= 1'b0;

      if ((r_state == FAULT) && clr_fault) begin
        // Clear beats a coincident sample: the sample is discarded and the
        // next valid sample is treated as a fresh first sample.
        r_state <= ACQ;
        run_len <= '0;
      end else if (count_vld) begin
        r_prev <= count;

        case (r_state)
          ACQ: begin
            r_state <= SEEN;
          end

          SEEN: begin
            case (w_step)
              UP: begin
                r_state <= TRACK_UP;
                dir     <= 1'b1;
                run_len <= c_RUN_ONE;
                wrap_up <= w_wrap_up;
              end
              DN: begin
                r_state <= TRACK_DN;
                dir     <= 1'b0;
                run_len <= c_RUN_ONE;
                wrap_dn <= w_wrap_dn;
              end
              STALL: begin
                stall <= 1'b1;
              end
              default: begin
                // A jump before lock just re-seeds prev (done above)
              end
            endcase
          end

          TRACK_UP, TRACK_DN: begin
            case (w_step)
              UP: begin
                wrap_up <= w_wrap_up;
                if (r_state == TRACK_UP) begin
                  if (run_len != c_RUN_MAX) run_len <= run_len + c_RUN_ONE;
                end else begin
                  r_state <= TRACK_UP;
                  dir     <= 1'b1;
                  run_len <= c_RUN_ONE;
`ifdef REV_CNT_EN
                  if (rev_cnt != c_REV_MAX) rev_cnt <= rev_cnt + c_REV_ONE;
`endif
                end
              end
              DN: begin
                wrap_dn <= w_wrap_dn;
                if (r_state == TRACK_DN) begin
                  if (run_len != c_RUN_MAX) run_len <= run_len + c_RUN_ONE;
                end else begin
                  r_state <= TRACK_DN;
                  dir     <= 1'b0;
                  run_len <= c_RUN_ONE;
`ifdef REV_CNT_EN
                  if (rev_cnt != c_REV_MAX) rev_cnt <= rev_cnt + c_REV_ONE;
`endif
                end
              end
              STALL: begin
                stall <= 1'b1;
              end
              default: begin
                err     <= 1'b1;
                r_state <= FAULT;
                run_len <= '0;
              end
            endcase
          end

          FAULT: begin
            // Samples keep prev current but raise nothing
          end

          default: begin
            r_state <= ACQ;
          end
        endcase
      end
    end
  end

endmodule : ud_count_decoder
`default_nettype wire

// File: tb/tb_ud_count_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ud_count_decoder
//  Description : Self-checking bench for ud_count_decoder. Directed scenarios
//                followed by randomized samples, all compared against a
//                behavioural model built from the decoder's rules (delta
//                modulo 16, lock/fault flags, saturating counts).
//  Config      : honours REV_CNT_EN (rev_cnt port and checks).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ud_count_decoder;

  localparam int W    = 4;
  localparam int MOD  = 16;
  localparam int MAXV = 15;
  localparam int SAT  = 255;

  logic         clk;
  logic         reset;
  logic [W-1:0] count;
  logic         count_vld;
  logic         clr_fault;
  logic         dir, dir_vld, wrap_up, wrap_dn, stall, err, fault;
  logic [7:0]   run_len;
`ifdef REV_CNT_EN
  logic [7:0]   rev_cnt;
`endif

  ud_count_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .count_vld (count_vld),
    .clr_fault (clr_fault),
    .dir       (dir),
    .dir_vld   (dir_vld),
    .wrap_up   (wrap_up),
    .wrap_dn   (wrap_dn),
    .stall     (stall),
    .err       (err),
    .fault     (fault),
    .run_len   (run_len)
`ifdef REV_CNT_EN
    ,
    .rev_cnt   (rev_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural model ----------------
  bit m_have, m_locked, m_fault, m_dir;
  int m_prev, m_run, m_rev;
  bit e_wu, e_wd, e_st, e_err;

  task automatic model_reset();
    m_have = 0; m_locked = 0; m_fault = 0; m_dir = 0;
    m_prev = 0; m_run = 0; m_rev = 0;
    e_wu = 0; e_wd = 0; e_st = 0; e_err = 0;
  endtask

  task automatic model_step(input bit vld, input int val, input bit clr);
    int d;
    bit up;
    e_wu = 0; e_wd = 0; e_st = 0; e_err = 0;
    if (m_fault && clr) begin
      m_fault = 0; m_have = 0; m_locked = 0; m_run = 0;
    end else if (vld) begin
      if (!m_have) begin
        m_have = 1;
      end else if (!m_fault) begin
        d = (val - m_prev + MOD) % MOD;
        if (d == 0) begin
          e_st = 1;
        end else if (d == 1 || d == MOD - 1) begin
          up = (d == 1);
          e_wu = up && (m_prev == MAXV);
          e_wd = !up && (m_prev == 0);
          if (!m_locked) begin
            m_locked = 1; m_dir = up; m_run = 1;
          end else if (up == m_dir) begin
            m_run = (m_run < SAT) ? m_run + 1 : SAT;
          end else begin
            m_dir = up; m_run = 1;
            m_rev = (m_rev < SAT) ? m_rev + 1 : SAT;
          end
        end else if (m_locked) begin
          e_err = 1; m_fault = 1; m_locked = 0; m_run = 0;
        end
      end
      m_prev = val;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dir_vld"}, 32'(dir_vld), 32'(m_locked));
    chk({tag, ".fault"},   32'(fault),   32'(m_fault));
    chk({tag, ".dir"},     32'(dir),     32'(m_dir));
    chk({tag, ".wrap_up"}, 32'(wrap_up), 32'(e_wu));
    chk({tag, ".wrap_dn"}, 32'(wrap_dn), 32'(e_wd));
    chk({tag, ".stall"},   32'(stall),   32'(e_st));
    chk({tag, ".err"},     32'(err),     32'(e_err));
    chk({tag, ".run_len"}, 32'(run_len), 32'(m_run));
`ifdef REV_CNT_EN
    chk({tag, ".rev_cnt"}, 32'(rev_cnt), 32'(m_rev));
`endif
  endtask

  // Drive one cycle (called at posedge+1), then check at the next posedge+1
  task automatic step(input bit vld, input int val, input bit clr, input string tag);
    count     = val[W-1:0];
    count_vld = vld;
    clr_fault = clr;
    @(posedge clk); #1;
    model_step(vld, val, clr);
    check_all(tag);
  endtask

  task automatic smp(input int val, input string tag);
    step(1'b1, val, 1'b0, tag);
  endtask

  task automatic do_reset();
    reset = 1'b0; count_vld = 1'b0; clr_fault = 1'b0; count = '0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; count = '0; count_vld = 1'b0; clr_fault = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    reset = 1'b1;

    // 0,1,2,3: lock up after the 2nd sample, run_len 3 after the 4th
    smp(0, "s1a"); chk("s1a.dir_vld_pre", 32'(dir_vld), 0);
    smp(1, "s1b"); chk("s1b.dir_vld", 32'(dir_vld), 1); chk("s1b.dir", 32'(dir), 1);
    smp(2, "s1c");
    smp(3, "s1d"); chk("s1d.run_len", 32'(run_len), 3);
    step(1'b0, 3, 1'b0, "s1idle");

    // 14,15,0: wrap_up after the 0 sample
    do_reset();
    smp(14, "s2a"); smp(15, "s2b");
    smp(0, "s2c"); chk("s2c.wrap_up", 32'(wrap_up), 1); chk("s2c.dir", 32'(dir), 1);
    step(1'b0, 0, 1'b0, "s2idle");

    // 1,0,15: down lock, wrap_dn, run_len 2
    do_reset();
    smp(1, "s3a"); smp(0, "s3b");
    smp(15, "s3c"); chk("s3c.wrap_dn", 32'(wrap_dn), 1); chk("s3c.run_len", 32'(run_len), 2);
    chk("s3c.dir", 32'(dir), 0);

    // 5,6,5: reversal
    do_reset();
    smp(5, "s4a"); smp(6, "s4b");
    smp(5, "s4c"); chk("s4c.dir", 32'(dir), 0); chk("s4c.run_len", 32'(run_len), 1);
`ifdef REV_CNT_EN
    chk("s4c.rev_cnt", 32'(rev_cnt), 1);
`endif

    // 3,4,9: jump -> fault; clr with a coincident sample discards it; 9,10 relock
    do_reset();
    smp(3, "s5a"); smp(4, "s5b");
    smp(9, "s5c"); chk("s5c.err", 32'(err), 1); chk("s5c.fault", 32'(fault), 1);
    chk("s5c.dir_vld", 32'(dir_vld), 0);
    smp(2, "s5d");
    step(1'b1, 3, 1'b1, "s5clr"); chk("s5clr.fault", 32'(fault), 0);
    smp(9, "s5e"); smp(10, "s5f"); chk("s5f.dir_vld", 32'(dir_vld), 1);

    // 7,7: stall; then async reset mid-run
    do_reset();
    smp(7, "s6a"); smp(7, "s6b"); chk("s6b.stall", 32'(stall), 1);
    smp(8, "s6c"); smp(9, "s6d");
    count = 4'd10; count_vld = 1'b1;
    reset = 1'b0; #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("async_rst_hold");
    reset = 1'b1;

    // run_len saturation over a long up run with wraps
    do_reset();
    for (int i = 0; i < 300; i++) smp(i % MOD, "sat");
    chk("sat.run_len", 32'(run_len), 255);

    // randomized samples
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int k;
      int v;
      bit c;
      bit vld;
      k = int'($urandom_range(0, 19));
      c = 1'b0;
      vld = 1'b1;
      if (m_fault && k < 5) begin
        c = 1'b1;
        vld = $urandom_range(0, 1) == 1;
      end
      if (k < 8)        v = (m_prev + 1) % MOD;
      else if (k < 13)  v = (m_prev + MOD - 1) % MOD;
      else if (k < 15)  v = m_prev;
      else if (k < 17)  v = (m_prev + int'($urandom_range(2, 14))) % MOD;
      else if (k < 18)  v = int'($urandom_range(0, MAXV));
      else begin
        v = int'($urandom_range(0, MAXV));
        vld = 1'b0;
      end
      step(vld, v, c, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ud_count_decoder
`default_nettype wire
